// File: rtl/score_pkg.sv
// score_pkg: game state encodings, BCD digit width and the saturating
// arithmetic helpers shared by the score tracker and its BCD converter.
package score_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    GAME_START = 3'b001,
    GAME_CLEAR = 3'b010,
    GAME_FAIL  = 3'b011
  } game_state_e;

  localparam int BCD_DIGIT_W = 4;

  // Upper clamp used after an addition; the caller hands in the unclamped sum.
  function automatic int unsigned clamp_max(input int unsigned value, input int unsigned ceil_val);
    return (value > ceil_val) ? ceil_val : value;
  endfunction

  // Subtraction that stops at zero instead of wrapping.
  function automatic int unsigned floor_sub(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : 0;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble (shift-add-3) binary to BCD converter.
// One shift per cycle: SCORE_W cycles in SHIFT plus one cycle in DONE, so the
// converter is busy for SCORE_W+1 cycles after a start. bcd is only meaningful
// while done is high.
module bin2bcd_seq #(
  parameter int SCORE_W = 7,
  parameter int DIGITS  = 2
) (
  input  logic                                     i_Clk,
  input  logic                                     i_Rst,
  input  logic                                     start,
  input  logic [SCORE_W-1:0]                       bin,
  output logic                                     busy,
  output logic                                     done,
  output logic [score_pkg::BCD_DIGIT_W*DIGITS-1:0] bcd
);

  localparam int DW    = score_pkg::BCD_DIGIT_W;
  localparam int BCD_W = DW * DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } conv_state_e;

  conv_state_e              state_reg, state_next;
  logic [SCORE_W-1:0]       bin_reg;
  logic [BCD_W-1:0]         bcd_reg;
  logic [BCD_W-1:0]         adj;
  logic [BCD_W+SCORE_W-1:0] shifted;
  logic [CNT_W-1:0]         cnt_reg;

  // Add 3 to every digit of 5 or more so the following shift carries correctly.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[gi*DW +: DW] = (bcd_reg[gi*DW +: DW] >= 4'd5) ?
                                (bcd_reg[gi*DW +: DW] + 4'd3) : bcd_reg[gi*DW +: DW];
    end
  endgenerate

  // The binary MSB shifts into digit 0 of the BCD accumulator.
  assign shifted = {adj, bin_reg} << 1;

  // State register.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: start -> SCORE_W shifts -> one DONE cycle -> IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt_reg == CNT_W'(SCORE_W - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on start, then one shift-add-3 step per SHIFT cycle.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      bin_reg <= '0;
      bcd_reg <= '0;
      cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            bin_reg <= bin;
            bcd_reg <= '0;
            cnt_reg <= '0;
          end
        end
        SHIFT: begin
          bcd_reg <= shifted[BCD_W+SCORE_W-1:SCORE_W];
          bin_reg <= shifted[SCORE_W-1:0];
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign bcd  = bcd_reg;

endmodule

// File: rtl/score_bcd_tracker.sv
// score_bcd_tracker: binary game score with hit bonus, miss penalty, floor and
// saturation, streak counting, and a BCD copy for the 7-segment driver.
// Optional: define SCORE_HIGH_SCORE_EN to keep the best finished-game score on
// o_HighScore; otherwise o_HighScore is tied to zero.
module score_bcd_tracker
  import score_pkg::*;
#(
  parameter int DIGITS     = 2,
  parameter int SCORE_W    = 7,
  parameter int MAX_SCORE  = 99,
  parameter int PENALTY    = 1,
  parameter int STREAK_LEN = 3,
  parameter int BONUS      = 2
) (
  input  logic                              i_Clk,
  input  logic                              i_Rst,
  input  logic [2:0]                        i_State,
  input  logic                              i_Sec1Tick,
  input  logic                              i_Comparison,
  input  logic                              i_Clear,
  output logic [SCORE_W-1:0]                o_Score,
  output logic [BCD_DIGIT_W*DIGITS-1:0]     o_ScoreBcd,
  output logic                              o_BcdValid,
  output logic [$clog2(STREAK_LEN+1)-1:0]   o_Streak,
  output logic                              o_Sat,
  output logic [SCORE_W-1:0]                o_HighScore
);

  localparam int STREAK_W = $clog2(STREAK_LEN + 1);
  localparam int BCD_W    = BCD_DIGIT_W * DIGITS;
  localparam logic [SCORE_W:0] HIT_INC   = (SCORE_W+1)'(1);
  localparam logic [SCORE_W:0] BONUS_INC = (SCORE_W+1)'(1 + BONUS);

  logic [SCORE_W-1:0]  score_reg, score_next;
  logic [STREAK_W-1:0] streak_reg, streak_next;
  logic [2:0]          prev_state_reg;
  logic [SCORE_W:0]    sum_w;
  logic                clear, score_event, streak_done, chg;
  logic                conv_start, conv_busy, conv_done;
  logic [BCD_W-1:0]    conv_bcd, bcd_reg;
  logic                bcd_valid_reg, pending_reg;

  // A fresh game (IDLE -> GAME_START) clears just like an explicit clear.
  assign clear       = i_Clear || ((prev_state_reg == IDLE) && (i_State == GAME_START));
  assign score_event = (i_State == GAME_START) && i_Sec1Tick;
  assign streak_done = (streak_reg == STREAK_W'(STREAK_LEN - 1));
  // One spare bit so the sum cannot wrap before it is clamped.
  assign sum_w       = {1'b0, score_reg} + (streak_done ? BONUS_INC : HIT_INC);

  // Next score/streak: clear beats a scoring event; other states freeze both.
  always_comb begin
    score_next  = score_reg;
    streak_next = streak_reg;
    if (clear) begin
      score_next  = '0;
      streak_next = '0;
    end else if (score_event) begin
      if (i_Comparison) begin
        score_next  = SCORE_W'(clamp_max(32'(sum_w), MAX_SCORE));
        streak_next = streak_done ? '0 : (streak_reg + STREAK_W'(1));
      end else begin
        score_next  = SCORE_W'(floor_sub(32'(score_reg), PENALTY));
        streak_next = '0;
      end
    end
  end

  // Score, streak and previous-state registers.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      score_reg      <= '0;
      streak_reg     <= '0;
      prev_state_reg <= IDLE;
    end else begin
      score_reg      <= score_next;
      streak_reg     <= streak_next;
      prev_state_reg <= i_State;
    end
  end

  // Conversion launches on the same edge the score changes, using the new
  // value; a change while the converter is busy is remembered and relaunched
  // from the then-current score once the converter returns to idle.
  assign chg        = (score_next != score_reg);
  assign conv_start = (chg || pending_reg) && !conv_busy;

  bin2bcd_seq #(
    .SCORE_W (SCORE_W),
    .DIGITS  (DIGITS)
  ) u_bin2bcd (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .start (conv_start),
    .bin   (score_next),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Publish only conversions that no later score change has overtaken; the
  // visible BCD holds its last good value while a conversion is outstanding.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      pending_reg   <= 1'b0;
      bcd_valid_reg <= 1'b1;
      bcd_reg       <= '0;
    end else begin
      if (conv_start)   pending_reg <= 1'b0;
      else if (chg)     pending_reg <= 1'b1;

      if (chg) begin
        bcd_valid_reg <= 1'b0;
      end else if (conv_done && !pending_reg) begin
        bcd_valid_reg <= 1'b1;
        bcd_reg       <= conv_bcd;
      end
    end
  end

  assign o_Score    = score_reg;
  assign o_Streak   = streak_reg;
  assign o_ScoreBcd = bcd_reg;
  assign o_BcdValid = bcd_valid_reg;
  assign o_Sat      = (score_reg == SCORE_W'(MAX_SCORE));

`ifdef SCORE_HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_score_reg;
  logic               game_over_entry;

  assign game_over_entry = ((i_State == GAME_CLEAR) || (i_State == GAME_FAIL)) &&
                           (i_State != prev_state_reg);

  // Keep the best score seen on entry to a finished-game state; survives clears.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst)                                            high_score_reg <= '0;
    else if (game_over_entry && (score_reg > high_score_reg)) high_score_reg <= score_reg;
  end

  assign o_HighScore = high_score_reg;
`else
  assign o_HighScore = '0;
`endif

endmodule

// File: tb/tb_score_bcd_tracker.sv
// tb_score_bcd_tracker: directed scoreboard bench for score_bcd_tracker with
// default parameters (2 digits, 7-bit score, ceiling 99, penalty 1, streak 3,
// bonus 2). Expected score/streak are pushed when a cycle is driven and popped
// after the clock edge; a background monitor requires the BCD shown while
// valid to match the expected score.
module tb_score_bcd_tracker;
  import score_pkg::*;

  logic       i_Clk        = 1'b0;
  logic       i_Rst        = 1'b1;
  logic [2:0] i_State      = IDLE;
  logic       i_Sec1Tick   = 1'b0;
  logic       i_Comparison = 1'b0;
  logic       i_Clear      = 1'b0;

  logic [6:0] o_Score;
  logic [7:0] o_ScoreBcd;
  logic       o_BcdValid;
  logic [1:0] o_Streak;
  logic       o_Sat;
  logic [6:0] o_HighScore;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int score;
    int streak;
  } exp_t;
  exp_t exp_q[$];

  int         model_score  = 0;
  int         model_streak = 0;
  int         model_hs     = 0;
  int         exp_now      = 0;
  logic [2:0] model_prev   = IDLE;

  score_bcd_tracker dut (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_State      (i_State),
    .i_Sec1Tick   (i_Sec1Tick),
    .i_Comparison (i_Comparison),
    .i_Clear      (i_Clear),
    .o_Score      (o_Score),
    .o_ScoreBcd   (o_ScoreBcd),
    .o_BcdValid   (o_BcdValid),
    .o_Streak     (o_Streak),
    .o_Sat        (o_Sat),
    .o_HighScore  (o_HighScore)
  );

  always #10 i_Clk = ~i_Clk;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock cycle of stimulus; the bench model predicts score/streak.
  task automatic drive(input logic [2:0] s, input logic tick, input logic hit,
                       input logic clr, input string tag);
    exp_t e;
    i_State      = s;
    i_Sec1Tick   = tick;
    i_Comparison = hit;
    i_Clear      = clr;
`ifdef SCORE_HIGH_SCORE_EN
    if ((s == GAME_CLEAR || s == GAME_FAIL) && s != model_prev && model_score > model_hs)
      model_hs = model_score;
`endif
    if (clr || (model_prev == IDLE && s == GAME_START)) begin
      model_score  = 0;
      model_streak = 0;
    end else if (s == GAME_START && tick) begin
      if (hit) begin
        if (model_streak == 2) begin
          model_score  = model_score + 3;
          model_streak = 0;
        end else begin
          model_score  = model_score + 1;
          model_streak = model_streak + 1;
        end
        if (model_score > 99) model_score = 99;
      end else begin
        model_streak = 0;
        if (model_score > 0) model_score = model_score - 1;
      end
    end
    model_prev = s;
    e.score  = model_score;
    e.streak = model_streak;
    exp_q.push_back(e);
    @(posedge i_Clk);
    #1;
    i_Sec1Tick   = 1'b0;
    i_Clear      = 1'b0;
    i_Comparison = 1'b0;
    e = exp_q.pop_front();
    $display("step %-12s state=%0d score=%0d streak=%0d", tag, s, o_Score, o_Streak);
    check({tag, " score"}, 32'(o_Score), 32'(e.score));
    check({tag, " streak"}, 32'(o_Streak), 32'(e.streak));
    exp_now = e.score;
  endtask

  // Wait (bounded) for the BCD copy to become valid and compare it.
  task automatic wait_bcd(input int maxc, input string tag);
    int n;
    n = 0;
    while (o_BcdValid !== 1'b1 && n < maxc) begin
      @(posedge i_Clk);
      #1;
      n++;
    end
    $display("bcd  %-12s valid=%0b bcd=%h after %0d cycles", tag, o_BcdValid, o_ScoreBcd, n);
    check({tag, " valid"}, 32'(o_BcdValid), 32'(1));
    check({tag, " bcd"}, 32'(o_ScoreBcd), 32'(to_bcd(model_score)));
  endtask

  // Whenever the DUT claims a valid BCD it must match the expected score.
  always @(negedge i_Clk) begin
    if (i_Rst === 1'b1 && o_BcdValid === 1'b1)
      check("bcd_fresh", 32'(o_ScoreBcd), 32'(to_bcd(exp_now)));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset: outputs take reset values without a clock edge.
    #2 i_Rst = 1'b0;
    #3;
    check("rst score", 32'(o_Score), 32'(0));
    check("rst bcd", 32'(o_ScoreBcd), 32'(0));
    check("rst valid", 32'(o_BcdValid), 32'(1));
    check("rst streak", 32'(o_Streak), 32'(0));
    check("rst sat", 32'(o_Sat), 32'(0));
    check("rst high", 32'(o_HighScore), 32'(0));
    repeat (2) @(posedge i_Clk);
    #1 i_Rst = 1'b1;

    // Fresh game and three hits: 1, 2, 5 with streak 1, 2, 0.
    drive(IDLE, 1'b0, 1'b0, 1'b0, "idle");
    drive(GAME_START, 1'b0, 1'b0, 1'b0, "start");
    for (int k = 0; k < 3; k++) begin
      drive(GAME_START, 1'b1, 1'b1, 1'b0, "hit");
      wait_bcd(8, "hit_bcd");
    end
    check("three_hits score", 32'(o_Score), 32'(5));
    check("three_hits bcd", 32'(o_ScoreBcd), 32'(8'h05));

    // Floor: 1 -> miss -> 0 -> miss -> still 0.
    drive(GAME_START, 1'b0, 1'b0, 1'b1, "clr");
    drive(GAME_START, 1'b1, 1'b1, 1'b0, "hit1");
    drive(GAME_START, 1'b1, 1'b0, 1'b0, "miss1");
    drive(GAME_START, 1'b1, 1'b0, 1'b0, "miss0");
    check("floor score", 32'(o_Score), 32'(0));
    wait_bcd(20, "floor_bcd");

    // Saturation: reach 97 with streak 2, then a bonus hit clamps to 99.
    drive(GAME_START, 1'b0, 1'b0, 1'b1, "clr");
    for (int k = 0; k < 59; k++) drive(GAME_START, 1'b1, 1'b1, 1'b0, "climb");
    check("pre_sat score", 32'(o_Score), 32'(97));
    check("pre_sat sat", 32'(o_Sat), 32'(0));
    drive(GAME_START, 1'b1, 1'b1, 1'b0, "sat_hit");
    check("sat score", 32'(o_Score), 32'(99));
    check("sat flag", 32'(o_Sat), 32'(1));
    drive(GAME_START, 1'b1, 1'b1, 1'b0, "sat_hold");
    check("sat_hold flag", 32'(o_Sat), 32'(1));
    wait_bcd(40, "sat_bcd");

    // Second tick arrives while the first conversion is still running.
    drive(GAME_START, 1'b0, 1'b0, 1'b1, "clr");
    wait_bcd(20, "clr_bcd");
    drive(GAME_START, 1'b1, 1'b1, 1'b0, "ovl_hit1");
    drive(GAME_START, 1'b0, 1'b0, 1'b0, "ovl_gap");
    drive(GAME_START, 1'b1, 1'b1, 1'b0, "ovl_hit2");
    wait_bcd(40, "overlap_bcd");
    check("overlap bcd", 32'(o_ScoreBcd), 32'(8'h02));

    // Frozen in GAME_FAIL; a new game clears; clear beats a same-cycle tick.
    drive(GAME_FAIL, 1'b1, 1'b1, 1'b0, "fail_hit");
    drive(GAME_FAIL, 1'b1, 1'b0, 1'b0, "fail_miss");
    check("frozen score", 32'(o_Score), 32'(2));
    drive(IDLE, 1'b0, 1'b0, 1'b0, "idle");
    drive(GAME_START, 1'b0, 1'b0, 1'b0, "restart");
    check("restart score", 32'(o_Score), 32'(0));
    drive(GAME_START, 1'b1, 1'b1, 1'b0, "hit");
    drive(GAME_START, 1'b1, 1'b1, 1'b1, "clr_tick");
    check("clr_tick score", 32'(o_Score), 32'(0));
    wait_bcd(20, "clr_tick_bcd");

    // Game 1 ends at 42 (GAME_CLEAR), game 2 ends at 17 (GAME_FAIL).
    drive(GAME_START, 1'b0, 1'b0, 1'b1, "clr");
    for (int k = 0; k < 26; k++) drive(GAME_START, 1'b1, 1'b1, 1'b0, "game1");
    drive(GAME_CLEAR, 1'b1, 1'b1, 1'b0, "g1_end");
    check("game1 score", 32'(o_Score), 32'(42));
    drive(IDLE, 1'b0, 1'b0, 1'b0, "idle");
    drive(GAME_START, 1'b0, 1'b0, 1'b0, "restart");
    for (int k = 0; k < 11; k++) drive(GAME_START, 1'b1, 1'b1, 1'b0, "game2");
    drive(GAME_FAIL, 1'b0, 1'b0, 1'b0, "g2_end");
    drive(GAME_FAIL, 1'b0, 1'b0, 1'b0, "g2_hold");
    check("game2 score", 32'(o_Score), 32'(17));
    check("high score", 32'(o_HighScore), 32'(model_hs));
    wait_bcd(20, "final_bcd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
